// File: rtl/frame_buffer_writer.sv
// rtl/frame_buffer_writer.sv - streamed RGB pixel writer into frame memory; FB_DOUBLE_BUFFER_EN selects vsync-swapped double buffering
module frame_buffer_writer #(
    parameter int H_DISP = 800,
    parameter int V_DISP = 600,
    parameter int ADDR_W = 19,
    parameter int PIX_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [PIX_W-1:0]  i_pixel,
    input  logic              i_sof,
    input  logic              i_vs,
    output logic              o_wr_en,
    output logic              o_wr_buf,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [PIX_W-1:0]  o_wr_data,
    output logic              o_disp_buf,
    output logic              o_frame_done,
    output logic              o_sof_err
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_DISP * V_DISP - 1);

`ifdef FB_DOUBLE_BUFFER_EN
    typedef enum logic [1:0] {IDLE, FILL, WAIT_SWAP} state_t;
`else
    typedef enum logic [0:0] {IDLE, FILL} state_t;
`endif

    state_t            state, state_d;
    logic [ADDR_W-1:0] cnt, cnt_d;
    logic              wr_en_d, sof_err_d, done_d, swap_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [PIX_W-1:0]  wr_data_d;
    logic              accept;

`ifdef FB_DOUBLE_BUFFER_EN
    logic vs_q;
    logic disp_q;
    logic vs_fall;

    assign vs_fall    = vs_q & ~i_vs;
    assign o_ready    = (state != WAIT_SWAP);
    assign o_disp_buf = disp_q;
    assign o_wr_buf   = ~disp_q;

    // Vsync edge history and the displayed-buffer select, flipped only at a sync-pulse start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q   <= 1'b1;
            disp_q <= 1'b0;
        end else begin
            vs_q <= i_vs;
            if (swap_d) begin
                disp_q <= ~disp_q;
            end
        end
    end
`else
    logic unused_vs;

    assign unused_vs  = i_vs;
    assign o_ready    = 1'b1;
    assign o_disp_buf = 1'b0;
    assign o_wr_buf   = 1'b0;
`endif

    assign accept = i_valid & o_ready;

    // Next-state and write/pulse decode; a sof beat always restarts the frame at address 0
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        wr_en_d   = 1'b0;
        wr_addr_d = o_wr_addr;
        wr_data_d = o_wr_data;
        sof_err_d = 1'b0;
        done_d    = 1'b0;
        swap_d    = 1'b0;
        case (state)
            IDLE: begin
                if (accept && i_sof) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = i_pixel;
                    cnt_d     = ADDR_W'(1);
                    state_d   = FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = i_pixel;
                    if (i_sof) begin
                        sof_err_d = 1'b1;
                        wr_addr_d = '0;
                        cnt_d     = ADDR_W'(1);
                    end else begin
                        wr_addr_d = cnt;
                        cnt_d     = cnt + ADDR_W'(1);
                        if (cnt == LAST) begin
`ifdef FB_DOUBLE_BUFFER_EN
                            state_d = WAIT_SWAP;
`else
                            state_d = IDLE;
                            done_d  = 1'b1;
`endif
                        end
                    end
                end
            end
`ifdef FB_DOUBLE_BUFFER_EN
            WAIT_SWAP: begin
                if (vs_fall) begin
                    swap_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State, pixel counter and registered memory-write / pulse outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_sof_err    <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            o_wr_en      <= wr_en_d;
            o_wr_addr    <= wr_addr_d;
            o_wr_data    <= wr_data_d;
            o_sof_err    <= sof_err_d;
            o_frame_done <= done_d;
        end
    end

endmodule

// File: doc/frame_buffer_writer.md
# frame_buffer_writer

Accepts a streamed 3-bit RGB picture (one bit per colour) from the picture loader and writes it into the 800x600 frame memories that the VGA scan-out stage reads. It double-buffers: the loader fills the back buffer while the scan-out displays the front buffer. The buffers swap only at the start of a vertical sync pulse, so a frame never tears. `o_disp_buf` drives the scan-out's picture-select input.

## Interface
Parameters:
- `H_DISP`, default 800: active pixels per line.
- `V_DISP`, default 600: active lines per frame.
- `ADDR_W`, default 19: frame-memory address width. Must satisfy 2^ADDR_W >= H_DISP*V_DISP.
- `PIX_W`, default 3: pixel width, {R,G,B}.

Ports:
- `clk`, input, 1: pixel clock, shared with the VGA scan-out.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `i_valid`, input, 1: the loader presents a pixel beat.
- `o_ready`, output, 1: the block accepts a beat this cycle.
- `i_pixel`, input, PIX_W: pixel data.
- `i_sof`, input, 1: start-of-frame marker. Qualifies the beat carrying pixel 0.
- `i_vs`, input, 1: VGA_VS from the scan-out. Already in the clk domain. Low during the sync pulse.
- `o_wr_en`, output, 1: frame-memory write strobe.
- `o_wr_buf`, output, 1: buffer being written (0/1).
- `o_wr_addr`, output, ADDR_W: write address, row-major.
- `o_wr_data`, output, PIX_W: write data.
- `o_disp_buf`, output, 1: buffer to display. Goes to the scan-out picture select.
- `o_frame_done`, output, 1: one-cycle pulse when a frame is committed.
- `o_sof_err`, output, 1: one-cycle pulse when `i_sof` arrives mid-frame.

## Operation
- A handshake completes in a cycle when `i_valid && o_ready`.
- `o_ready` is combinational from state: 1 in IDLE and FILL, 0 in WAIT_SWAP.
- The pixel counter `cnt` is ADDR_W bits. LAST = H_DISP*V_DISP-1 = 479999.
- The back buffer is `~o_disp_buf`. `o_wr_buf` always equals the back buffer.

State machine:
- **IDLE**
  - An accepted beat with `i_sof=0` is consumed and discarded; no write.
  - An accepted beat with `i_sof=1` writes addr 0, sets `cnt`=1 and moves to FILL.
- **FILL**
  - An accepted beat without `i_sof` writes addr `cnt`, then `cnt`++.
  - An accepted beat with `i_sof` pulses `o_sof_err`, writes addr 0 and sets `cnt`=1 (resynchronises). The state stays FILL.
  - The beat written at addr LAST moves to WAIT_SWAP.
- **WAIT_SWAP**
  - Holds `o_ready`=0 and waits for a falling edge of `i_vs`.
  - Edge detect: `vs_q` <= `i_vs` every cycle; fall = `vs_q & ~i_vs`.
  - On fall: toggle `o_disp_buf`, pulse `o_frame_done`, go to IDLE.
  - A fall in the same cycle that LAST is accepted is ignored, because the state is still FILL.
- A `cnt` wrap never occurs: LAST always exits FILL.
- An `i_sof` on the LAST beat counts as mid-frame. It pulses `o_sof_err`, writes addr 0, and the state stays FILL.
- Reset mid-frame aborts the frame. Partially written back-buffer data is left as is. `o_disp_buf` returns to 0.

## Timing
- Reset values:
  - State IDLE, so `o_ready`=1 during and after reset. The loader must not drive beats during reset.
  - All registered outputs 0: `o_wr_en`, `o_wr_buf`=~0 is NOT used; `o_wr_buf`=1, `o_wr_addr`, `o_wr_data`, `o_disp_buf`, `o_frame_done`, `o_sof_err`, `vs_q`=1.
  - Correction for clarity: `o_wr_buf` resets to 1 (= ~`o_disp_buf`).
- Write latency: `o_wr_en`, `o_wr_addr` and `o_wr_data` are registered. They are asserted in the cycle after the handshake, for exactly one cycle per accepted beat.
- Swap latency: `o_disp_buf` and `o_wr_buf` toggle on the clock edge ending the cycle in which the fall is detected. `o_frame_done` is high in the following cycle.
- `o_sof_err` is registered and asserted the cycle after the offending handshake.
- Throughput: one pixel per cycle in FILL. No bubbles are inserted by the block.

## Configuration
- Macro: `FB_DOUBLE_BUFFER_EN`.
- Defined: double buffering, WAIT_SWAP and vsync-aligned swap exactly as described above.
- Not defined:
  - Single buffer. `o_wr_buf` and `o_disp_buf` are tied to 0; `vs_q` and the WAIT_SWAP state are removed.
  - Writing LAST returns directly to IDLE and pulses `o_frame_done` the next cycle. `i_vs` is ignored.

## Test plan
- **Full frame:** reset, then stream 480000 beats, `i_sof` on the first, `i_valid` held 1.
  - `o_wr_addr` runs 0..479999 on buffer 1.
  - `o_ready` drops after the last beat.
  - On `i_vs` 1->0, `o_disp_buf`=1 and `o_frame_done` pulses once.
- **Leading junk:** 5 beats without `i_sof` in IDLE, then a sof beat.
  - No `o_wr_en` for the junk.
  - The first write is addr 0 with the sof beat's data.
- **Mid-frame resync:** sof at beat 0, 100 beats, then sof again.
  - `o_sof_err` pulses once.
  - The next write is addr 0 and the following write is addr 1.
- **Swap waits for vsync:** finish a frame while `i_vs`=1 for 1000 cycles.
  - `o_ready`=0 and `o_disp_buf` is unchanged throughout.
  - The toggle happens exactly one cycle after `i_vs` falls.
  - Verify the second frame writes buffer 0.
- **Backpressure and gaps:** random `i_valid` gaps.
  - Addresses stay contiguous, with no duplicate or missing writes.
- **Reset mid-frame:** assert `rst_n`=0 at beat 2000.
  - All outputs return to reset values.
  - The next sof writes addr 0 on buffer 1.
